// File: rtl/bit_unpacker_pkg.sv
// Shared definitions for the AXI-Stream bit unpacker: register offsets, BPS codes,
// CFG reset value and the code -> bits-per-symbol / symbols-per-word helpers.
package bit_unpacker_pkg;

  localparam logic [19:0] REG_CFG    = 20'h00;
  localparam logic [19:0] REG_SPW    = 20'h04;
  localparam logic [19:0] REG_SYMCNT = 20'h08;

  localparam logic [1:0] BPS_CODE_1 = 2'd0;
  localparam logic [1:0] BPS_CODE_2 = 2'd1;
  localparam logic [1:0] BPS_CODE_4 = 2'd2;
  localparam logic [1:0] BPS_CODE_8 = 2'd3;

  // Reset configuration: 2 bits per symbol, MSB-first.
  localparam logic [1:0] CFG_RESET_CODE = BPS_CODE_2;
  localparam logic       CFG_RESET_MSB  = 1'b1;

  function automatic logic [3:0] code_to_bps(input logic [1:0] code);
    return 4'd1 << code;
  endfunction

  function automatic logic [31:0] code_to_spw(input logic [1:0] code, input int unsigned in_w);
    return 32'(in_w >> code);
  endfunction

endpackage

// File: rtl/bit_unpacker_regs.sv
// CtrlPort register file for the bit unpacker: CFG (RW), SPW (RO) and, when
// BIT_UNPACKER_SYMCNT_EN is defined, the SYMCNT output-handshake counter.
module bit_unpacker_regs
  import bit_unpacker_pkg::*;
#(
  parameter int          IN_W      = 32,
  parameter logic [19:0] BASE_ADDR = 20'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_wr,
  input  logic        req_rd,
  input  logic [19:0] req_addr,
  input  logic [31:0] req_data,
  output logic        resp_ack,
  output logic [31:0] resp_data,
  input  logic        out_hs,
  output logic [1:0]  cfg_code,
  output logic        cfg_msb
);

  localparam logic [19:0] ADDR_CFG    = BASE_ADDR + REG_CFG;
  localparam logic [19:0] ADDR_SPW    = BASE_ADDR + REG_SPW;
  localparam logic [19:0] ADDR_SYMCNT = BASE_ADDR + REG_SYMCNT;

  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  code_q, code_d;
  logic        msb_q, msb_d;
  logic [31:0] cfg_rd;
  logic [31:0] cnt_rd;

  assign cfg_rd = {23'b0, msb_q, 6'b0, code_q};

`ifdef BIT_UNPACKER_SYMCNT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        cnt_clr;

  assign cnt_clr = req_wr && (req_addr == ADDR_SYMCNT);
  assign cnt_rd  = cnt_q;

  // A clear coinciding with a handshake still counts that handshake.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)     cnt_d = out_hs ? 32'd1 : 32'd0;
    else if (out_hs) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_out_hs;
  assign unused_out_hs = out_hs;
  assign cnt_rd        = '0;
`endif

  always_comb begin
    ack_d   = req_wr || req_rd;
    rdata_d = '0;
    code_d  = code_q;
    msb_d   = msb_q;
    if (req_wr) begin
      if (req_addr == ADDR_CFG) begin
        code_d = req_data[1:0];
        msb_d  = req_data[8];
      end
    end else if (req_rd) begin
      if (req_addr == ADDR_CFG)         rdata_d = cfg_rd;
      else if (req_addr == ADDR_SPW)    rdata_d = code_to_spw(code_q, IN_W);
`ifdef BIT_UNPACKER_SYMCNT_EN
      else if (req_addr == ADDR_SYMCNT) rdata_d = cnt_rd;
`endif
      else                              rdata_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      code_q  <= CFG_RESET_CODE;
      msb_q   <= CFG_RESET_MSB;
    end else begin
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      code_q  <= code_d;
      msb_q   <= msb_d;
    end
  end

  assign resp_ack  = ack_q;
  assign resp_data = rdata_q;
  assign cfg_code  = code_q;
  assign cfg_msb   = msb_q;

endmodule

// File: rtl/axis_bit_unpacker.sv
// Splits each IN_W-bit input item into BPS-bit symbols, one zero-extended symbol per
// output item. Optional SYMCNT counter is enabled with BIT_UNPACKER_SYMCNT_EN.
module axis_bit_unpacker
  import bit_unpacker_pkg::*;
#(
  parameter int          IN_W      = 32,
  parameter int          OUT_W     = 32,
  parameter logic [19:0] BASE_ADDR = 20'h0
) (
  input  logic             axis_data_clk,
  input  logic             axis_data_rst,
  input  logic             s_ctrlport_req_wr,
  input  logic             s_ctrlport_req_rd,
  input  logic [19:0]      s_ctrlport_req_addr,
  input  logic [31:0]      s_ctrlport_req_data,
  output logic             s_ctrlport_resp_ack,
  output logic [31:0]      s_ctrlport_resp_data,
  input  logic [IN_W-1:0]  s_in_tdata,
  input  logic             s_in_tlast,
  input  logic             s_in_tvalid,
  output logic             s_in_tready,
  output logic [OUT_W-1:0] m_out_tdata,
  output logic             m_out_tlast,
  output logic             m_out_tvalid,
  input  logic             m_out_tready
);

  localparam int IDX_W = $clog2(IN_W);

  logic [IN_W-1:0]  word_q, word_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             full_q, full_d;
  logic             last_q, last_d;
  logic [1:0]       code_q, code_d;
  logic             msb_q, msb_d;
  logic             rdy_en_q;

  logic [1:0]       cfg_code;
  logic             cfg_msb;
  logic [IDX_W-1:0] last_idx;
  logic             at_last, in_hs, out_hs;
  logic [3:0]       bps;
  logic [31:0]      k_off, shamt;
  logic [IN_W-1:0]  shifted;
  logic [7:0]       sym;

  bit_unpacker_regs #(.IN_W(IN_W), .BASE_ADDR(BASE_ADDR)) u_regs (
    .clk       (axis_data_clk),
    .rst       (axis_data_rst),
    .req_wr    (s_ctrlport_req_wr),
    .req_rd    (s_ctrlport_req_rd),
    .req_addr  (s_ctrlport_req_addr),
    .req_data  (s_ctrlport_req_data),
    .resp_ack  (s_ctrlport_resp_ack),
    .resp_data (s_ctrlport_resp_data),
    .out_hs    (out_hs),
    .cfg_code  (cfg_code),
    .cfg_msb   (cfg_msb)
  );

  // Both streams are AXI-Stream: a transfer occurs on a rising edge where valid and
  // ready are both high; once valid is up, data and last hold until that transfer.
  assign last_idx    = IDX_W'(code_to_spw(code_q, IN_W) - 32'd1);
  assign at_last     = (idx_q == last_idx);
  assign s_in_tready = rdy_en_q && (!full_q || (at_last && m_out_tready));
  assign in_hs       = s_in_tvalid && s_in_tready;
  assign out_hs      = full_q && m_out_tready;

  // Symbol select uses the BPS/order latched with the word, not the live CFG.
  always_comb begin
    bps     = code_to_bps(code_q);
    k_off   = 32'(idx_q) * 32'(bps);
    shamt   = msb_q ? (32'(IN_W) - k_off - 32'(bps)) : k_off;
    shifted = word_q >> shamt;
    sym     = shifted[7:0] & 8'((9'd1 << bps) - 9'd1);
    m_out_tdata      = '0;
    m_out_tdata[7:0] = sym;
  end

  assign m_out_tvalid = full_q;
  assign m_out_tlast  = full_q && last_q && at_last;

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    full_d = full_q;
    last_d = last_q;
    code_d = code_q;
    msb_d  = msb_q;
    if (in_hs) begin
      word_d = s_in_tdata;
      idx_d  = '0;
      full_d = 1'b1;
      last_d = s_in_tlast;
      code_d = cfg_code;
      msb_d  = cfg_msb;
    end else if (out_hs) begin
      if (at_last) full_d = 1'b0;
      else         idx_d  = idx_q + 1'b1;
    end
  end

  always_ff @(posedge axis_data_clk or posedge axis_data_rst) begin
    if (axis_data_rst) begin
      word_q   <= '0;
      idx_q    <= '0;
      full_q   <= 1'b0;
      last_q   <= 1'b0;
      code_q   <= CFG_RESET_CODE;
      msb_q    <= CFG_RESET_MSB;
      rdy_en_q <= 1'b0;
    end else begin
      word_q   <= word_d;
      idx_q    <= idx_d;
      full_q   <= full_d;
      last_q   <= last_d;
      code_q   <= code_d;
      msb_q    <= msb_d;
      rdy_en_q <= 1'b1;
    end
  end

endmodule
